// File: rtl/morse_player.sv
// Plays one five-symbol Morse letter (2 bits per symbol, oldest in [9:8]) as
// timed tone pulses with unit-based mark, space and letter-gap durations.
module morse_player #(
  parameter int UNIT_TICKS = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] letra,
  input  logic       start,
  output logic       ready,
  output logic       tone,
  output logic       dot_led,
  output logic       dash_led,
  output logic       done
);

  localparam int DW = $clog2(3 * UNIT_TICKS + 1);
  localparam logic [DW-1:0] L_UNIT = DW'(UNIT_TICKS);
  localparam logic [DW-1:0] L_GAP  = DW'(2 * UNIT_TICKS);
  localparam logic [DW-1:0] L_DASH = DW'(3 * UNIT_TICKS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MARK, S_SPACE, S_LGAP, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_dur,   w_dur_nxt;
  logic [2:0]    r_idx,   w_idx_nxt;
  logic [9:0]    r_sr,    w_sr_nxt;
  logic          r_played, w_played_nxt;
  logic          r_dash,   w_dash_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_dur_nxt    = r_dur;
    w_idx_nxt    = r_idx;
    w_sr_nxt     = r_sr;
    w_played_nxt = r_played;
    w_dash_nxt   = r_dash;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sr_nxt     = letra;
          w_played_nxt = 1'b0;
          w_idx_nxt    = 3'd4;
          w_state_nxt  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_sr[9]) begin
          w_played_nxt = 1'b1;
          w_dash_nxt   = r_sr[8];
          w_dur_nxt    = r_sr[8] ? L_DASH : L_UNIT;
          w_state_nxt  = S_MARK;
        end else begin
          // Empty/reserved symbols cost one cycle and add no gap.
          w_sr_nxt = {r_sr[7:0], 2'b00};
          if (r_idx == 3'd0) begin
            w_state_nxt = r_played ? S_LGAP : S_DONE;
            w_dur_nxt   = r_played ? L_GAP : '0;
          end else begin
            w_idx_nxt = r_idx - 3'd1;
          end
        end
      end
      S_MARK: begin
        if (r_dur <= DW'(1)) begin
          w_dur_nxt   = L_UNIT;
          w_state_nxt = S_SPACE;
        end else begin
          w_dur_nxt = r_dur - DW'(1);
        end
      end
      S_SPACE: begin
        if (r_dur <= DW'(1)) begin
          if (r_idx == 3'd0) begin
            w_dur_nxt   = L_GAP;
            w_state_nxt = S_LGAP;
          end else begin
            w_sr_nxt    = {r_sr[7:0], 2'b00};
            w_idx_nxt   = r_idx - 3'd1;
            w_dur_nxt   = '0;
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_dur_nxt = r_dur - DW'(1);
        end
      end
      S_LGAP: begin
        // Final SPACE plus these two units form the three-unit letter gap.
        if (r_dur <= DW'(1)) begin
          w_dur_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_dur_nxt = r_dur - DW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are glitch-free flops
  // that switch on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_dur    <= '0;
      r_idx    <= '0;
      r_sr     <= '0;
      r_played <= 1'b0;
      r_dash   <= 1'b0;
      ready    <= 1'b1;
      tone     <= 1'b0;
      dot_led  <= 1'b0;
      dash_led <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dur    <= w_dur_nxt;
      r_idx    <= w_idx_nxt;
      r_sr     <= w_sr_nxt;
      r_played <= w_played_nxt;
      r_dash   <= w_dash_nxt;
      ready    <= (w_state_nxt == S_IDLE);
      tone     <= (w_state_nxt == S_MARK);
      dot_led  <= (w_state_nxt == S_MARK) && !w_dash_nxt;
      dash_led <= (w_state_nxt == S_MARK) && w_dash_nxt;
      done     <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_morse_player.sv
// Bench for morse_player: three instances with different unit lengths, a
// table of letters checked cycle by cycle against a symbol-timing model.
module tb_morse_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [9:0] letra [3];
  logic       start [3];
  logic       ready [3];
  logic       tone  [3];
  logic       dot   [3];
  logic       dash  [3];
  logic       done  [3];

  morse_player #(.UNIT_TICKS(4)) u0 (
    .clk(clk), .rst(rst), .letra(letra[0]), .start(start[0]), .ready(ready[0]),
    .tone(tone[0]), .dot_led(dot[0]), .dash_led(dash[0]), .done(done[0]));
  morse_player #(.UNIT_TICKS(2)) u1 (
    .clk(clk), .rst(rst), .letra(letra[1]), .start(start[1]), .ready(ready[1]),
    .tone(tone[1]), .dot_led(dot[1]), .dash_led(dash[1]), .done(done[1]));
  morse_player #(.UNIT_TICKS(3)) u2 (
    .clk(clk), .rst(rst), .letra(letra[2]), .start(start[2]), .ready(ready[2]),
    .tone(tone[2]), .dot_led(dot[2]), .dash_led(dash[2]), .done(done[2]));

  typedef struct {
    int         dut;
    logic [9:0] code;
    int         done_cyc;
    bit         disturb;
  } vec_t;

  vec_t       tbl [7];
  logic [4:0] exp_q [$];   // {ready, tone, dot, dash, done} per cycle
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic int ut(int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 3;
  endfunction

  function automatic logic [4:0] outs(int d);
    return {ready[d], tone[d], dot[d], dash[d], done[d]};
  endfunction

  task automatic chk(string nm, int act, int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Expected trace from cycle 1 up to and including the first idle cycle.
  task automatic gen(int u, logic [9:0] code);
    bit         played;
    logic [1:0] p;
    played = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      p = code[9-2*i -: 2];
      exp_q.push_back(5'b00000);
      if (p[1]) begin
        repeat (p[0] ? 3*u : u) exp_q.push_back({1'b0, 1'b1, ~p[0], p[0], 1'b0});
        repeat (u) exp_q.push_back(5'b00000);
        played = 1'b1;
      end
    end
    if (played) repeat (2*u) exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b10000);
  endtask

  task automatic play(string nm, int d, logic [9:0] code, int exp_done, bit disturb);
    int         k, done_at, ndone;
    logic [4:0] e, a;
    @(negedge clk);
    chk({nm, " ready_before"}, int'(ready[d]), 1);
    letra[d] = code;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    letra[d] = 10'($urandom);
    gen(ut(d), code);
    k = 1; done_at = -1; ndone = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = outs(d);
      chk($sformatf("%s c%0d", nm, k), int'(a), int'(e));
      if (a[0]) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (disturb && k == 6) begin
        start[d] = 1'b1;
        letra[d] = 10'h3FF;
      end
      if (disturb && k == 10) start[d] = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, " done_cycle"}, done_at, exp_done);
    chk({nm, " done_count"}, ndone, 1);
  endtask

  initial begin
    tbl[0] = '{0, 10'b00_00_00_10_11, 38, 1'b0};  // A
    tbl[1] = '{1, 10'b10_10_10_10_10, 30, 1'b0};  // 5
    tbl[2] = '{1, 10'b00_00_00_00_00,  6, 1'b0};  // empty
    tbl[3] = '{2, 10'b11_00_10_00_00, 30, 1'b0};  // interior skips
    tbl[4] = '{0, 10'b11_11_11_11_11, 94, 1'b0};  // five dashes
    tbl[5] = '{2, 10'b01_10_01_00_11, 30, 1'b0};  // reserved code skipped
    tbl[6] = '{0, 10'b00_00_00_10_11, 38, 1'b1};  // A, start/letra churn in MARK

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      letra[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("reset u%0d", d), int'(outs(d)), 5'b10000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      play($sformatf("v%0d", i), tbl[i].dut, tbl[i].code, tbl[i].done_cyc, tbl[i].disturb);

    // Reset on the third cycle of a dash, then a clean replay.
    @(negedge clk);
    letra[2] = 10'b11_00_10_00_00;
    start[2] = 1'b1;
    @(posedge clk);
    #1;
    start[2] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst pre tone", int'(tone[2]), 1);
    chk("rst pre dash", int'(dash[2]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst tone", int'(tone[2]), 0);
    chk("rst dash", int'(dash[2]), 0);
    chk("rst ready", int'(ready[2]), 1);
    chk("rst done", int'(done[2]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst nodone %0d", i), int'(outs(2)), 5'b10000);
      @(posedge clk);
      #1;
    end
    play("after_rst", 2, 10'b11_00_10_00_00, 30, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
